dmem_mmio: RTL and testbench

- Memory-stage data slave for the pipelined RISC-V core.
- Consumes the core's M-stage address (ALU_result), store data (Write_Data) and store strobe (MemWriteM), and returns Read_Data combinationally in the same cycle.
- Contains a word-addressed data RAM and a small memory-mapped I/O region:
  - GPIO output register
  - byte TX FIFO with a valid/ready drain port
  - free-running cycle counter

---
 rtl/dmem_mmio.sv | 216 +++++++++++++++++++++
 tb/tb_dmem_mmio.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio
// Purpose  : Memory-stage data slave for the pipelined RISC-V core. Holds a
//            word-addressed data RAM and a small MMIO region (GPIO register,
//            byte TX FIFO with valid/ready drain, free-running cycle counter).
//            Loads are combinational from the current address; stores commit
//            on the rising edge where MemWriteM is 1.
// Ports    : CLK, RST          clock / synchronous active-high reset
//            ALU_result        byte address (bits [1:0] ignored)
//            Write_Data        store data
//            MemWriteM         store strobe
//            Read_Data         combinational load data
//            gpio_out          GPIO output register
//            tx_data/tx_valid  FIFO head byte / FIFO not empty
//            tx_ready          consumer accepts the head byte
// Options  : DMEM_CYCLE_CNT_EN - when defined, the cycle counter at
//            0x8000_000C is built; otherwise that address reads 0 and
//            ignores writes.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  MemWriteM,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // MMIO register map, MSB set, word aligned.
  localparam logic [DATA_WIDTH-1:0] MMIO_BASE   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] GPIO_ADDR   = MMIO_BASE;
  localparam logic [DATA_WIDTH-1:0] TXDATA_ADDR = MMIO_BASE + DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] STATUS_ADDR = MMIO_BASE + DATA_WIDTH'(8);
`ifdef DMEM_CYCLE_CNT_EN
  localparam logic [DATA_WIDTH-1:0] CYCLE_ADDR  = MMIO_BASE + DATA_WIDTH'(12);
`endif

  // Byte offset within the word is don't-care for word-only accesses.
  logic [1:0] unused_byte_ofs;
  assign unused_byte_ofs = ALU_result[1:0];

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-3:0] word_addr;
  logic                  in_ram;
  logic [AW-1:0]         ram_idx;
  logic                  is_gpio;
  logic                  is_txdata;
  logic                  is_status;

  assign word_addr = ALU_result[DATA_WIDTH-1:2];
  // With MEM_DEPTH a power of two, "MSB clear and word index below depth"
  // reduces to all bits above the RAM index being zero.
  assign in_ram    = (ALU_result[DATA_WIDTH-1:AW+2] == '0);
  assign ram_idx   = ALU_result[AW+1:2];
  assign is_gpio   = (word_addr == GPIO_ADDR[DATA_WIDTH-1:2]);
  assign is_txdata = (word_addr == TXDATA_ADDR[DATA_WIDTH-1:2]);
  assign is_status = (word_addr == STATUS_ADDR[DATA_WIDTH-1:2]);

  // --------------------------------------------------------------------------
  // Data RAM (contents not reset; reset still blocks a write in its cycle)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];

  always_ff @(posedge CLK) begin
    if (!RST && MemWriteM && in_ram) begin
      ram[ram_idx] <= Write_Data;
    end
  end

  // --------------------------------------------------------------------------
  // GPIO register
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] gpio_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_q <= '0;
    end else if (MemWriteM && is_gpio) begin
      gpio_q <= Write_Data;
    end
  end

  assign gpio_out = gpio_q;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          ovf_clr;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = tx_valid && tx_ready;
  assign push_req = MemWriteM && is_txdata;
  // A pop in the same edge frees the head slot, so a full FIFO can still
  // accept the new byte.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = MemWriteM && is_status && Write_Data[2];

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      fifo_mem[wr_ptr] <= Write_Data[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overflow wins over a coincident clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  logic [DATA_WIDTH-1:0] status;

  always_comb begin
    status         = '0;
    status[0]      = empty;
    status[1]      = full;
    status[2]      = overflow;
    status[4 +: CW] = count;
  end

  // --------------------------------------------------------------------------
  // Cycle counter
  // --------------------------------------------------------------------------
`ifdef DMEM_CYCLE_CNT_EN
  logic                  is_cycle;
  logic [DATA_WIDTH-1:0] cycle_q;

  assign is_cycle = (word_addr == CYCLE_ADDR[DATA_WIDTH-1:2]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_q <= '0;
    end else if (MemWriteM && is_cycle) begin
      // Load replaces the increment on this edge.
      cycle_q <= Write_Data;
    end else begin
      cycle_q <= cycle_q + 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Load data mux (old value visible until the write edge)
  // --------------------------------------------------------------------------
  always_comb begin
    Read_Data = '0;
    if (in_ram) begin
      Read_Data = ram[ram_idx];
    end else if (is_gpio) begin
      Read_Data = gpio_q;
    end else if (is_status) begin
      Read_Data = status;
    end
`ifdef DMEM_CYCLE_CNT_EN
    else if (is_cycle) begin
      Read_Data = cycle_q;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio
// Purpose  : Directed self-checking bench for dmem_mmio. Inputs change on the
//            falling edge; outputs are sampled 1 time unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio;

  logic        CLK;
  logic        RST;
  logic [31:0] ALU_result;
  logic [31:0] Write_Data;
  logic        MemWriteM;
  logic [31:0] Read_Data;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_cmp;
  int n_fail;

  localparam logic [31:0] A_GPIO   = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE  = 32'h8000_000C;

  dmem_mmio dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_result(ALU_result),
    .Write_Data(Write_Data),
    .MemWriteM (MemWriteM),
    .Read_Data (Read_Data),
    .gpio_out  (gpio_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply one cycle of inputs at the falling edge, then settle.
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    @(negedge CLK);
    ALU_result = a;
    Write_Data = d;
    MemWriteM  = we;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    MemWriteM = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(A_STATUS, 32'h0, 1'b0);
    n_cmp++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio got %h want %h", gpio_out, 32'h0); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_cmp++; if (Read_Data !== 32'h1) begin n_fail++; $display("FAIL reset_status got %h want %h", Read_Data, 32'h1); end
  endtask

  task automatic test_ram();
    drive(32'h0000_0000, 32'hCAFE_0000, 1'b1);
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    drive(32'h0000_0010, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd_10 got %h want %h", Read_Data, 32'hDEAD_BEEF); end
    drive(32'h0000_0013, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd_13 got %h want %h", Read_Data, 32'hDEAD_BEEF); end
    drive(32'h0000_0100, 32'h1234_5678, 1'b1);
    drive(32'h0000_0100, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'h0) begin n_fail++; $display("FAIL ram_rd_oob got %h want %h", Read_Data, 32'h0); end
    drive(32'h0000_0000, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'hCAFE_0000) begin n_fail++; $display("FAIL ram_oob_alias got %h want %h", Read_Data, 32'hCAFE_0000); end
  endtask

  task automatic test_gpio_reset();
    drive(A_GPIO, 32'h0000_00A5, 1'b1);
    drive(A_GPIO, 32'h0, 1'b0);
    n_cmp++; if (gpio_out !== 32'hA5) begin n_fail++; $display("FAIL gpio_out got %h want %h", gpio_out, 32'hA5); end
    n_cmp++; if (Read_Data !== 32'hA5) begin n_fail++; $display("FAIL gpio_rd got %h want %h", Read_Data, 32'hA5); end
    do_reset();
    n_cmp++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL gpio_after_rst got %h want %h", gpio_out, 32'h0); end
  endtask

  task automatic test_reset_mid();
    drive(A_TXDATA, 32'h77, 1'b1);
    // Reset coincides with another push: both bytes must be gone.
    @(negedge CLK);
    RST = 1'b1;
    ALU_result = A_TXDATA;
    Write_Data = 32'h88;
    MemWriteM = 1'b1;
    drive(A_STATUS, 32'h0, 1'b0);
    RST = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", tx_valid); end
    drive(A_STATUS, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'h1) begin n_fail++; $display("FAIL rstmid_status got %h want %h", Read_Data, 32'h1); end
  endtask

  task automatic test_fifo_fill();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(A_TXDATA, {24'h0, bytes[i]}, 1'b1);
      if (i == 0) begin
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL push_same_cycle_valid got %b want 0", tx_valid); end
        n_cmp++; if (Read_Data !== 32'h0) begin n_fail++; $display("FAIL txdata_rd got %h want 0", Read_Data); end
      end
    end
    drive(A_STATUS, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'h42) begin n_fail++; $display("FAIL status_full got %h want %h", Read_Data, 32'h42); end
    n_cmp++; if (tx_data !== 8'h11) begin n_fail++; $display("FAIL head_full got %h want 11", tx_data); end
    drive(A_TXDATA, 32'h55, 1'b1);
    drive(A_STATUS, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'h46) begin n_fail++; $display("FAIL status_ovf got %h want %h", Read_Data, 32'h46); end
    drive(A_STATUS, 32'h4, 1'b1);
    drive(A_STATUS, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'h42) begin n_fail++; $display("FAIL status_clr got %h want %h", Read_Data, 32'h42); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [5];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h66;
    @(negedge CLK);
    tx_ready = 1'b1;
    ALU_result = A_TXDATA;
    Write_Data = 32'h66;
    MemWriteM = 1'b1;
    #1;
    n_cmp++; if (tx_data !== exp[0] || tx_valid !== 1'b1) begin n_fail++; $display("FAIL drain_0 got %h/%b want %h/1", tx_data, tx_valid, exp[0]); end
    for (int i = 1; i < 5; i++) begin
      drive(A_STATUS, 32'h0, 1'b0);
      n_cmp++; if (tx_data !== exp[i] || tx_valid !== 1'b1) begin n_fail++; $display("FAIL drain_%0d got %h/%b want %h/1", i, tx_data, tx_valid, exp[i]); end
      if (i == 1) begin
        n_cmp++; if (Read_Data !== 32'h42) begin n_fail++; $display("FAIL count_after_pushpop got %h want %h", Read_Data, 32'h42); end
      end
    end
    drive(A_STATUS, 32'h0, 1'b0);
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL drain_empty got %h/%b want 00/0", tx_data, tx_valid); end
    n_cmp++; if (Read_Data !== 32'h1) begin n_fail++; $display("FAIL status_empty got %h want %h", Read_Data, 32'h1); end
    tx_ready = 1'b0;
  endtask

  task automatic test_cycle();
    logic [31:0] exp_seq [3];
    logic [31:0] e;
`ifdef DMEM_CYCLE_CNT_EN
    exp_seq[0] = 32'hFFFF_FFFE; exp_seq[1] = 32'hFFFF_FFFF; exp_seq[2] = 32'h0;
    e = 32'd10;
`else
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h0; exp_seq[2] = 32'h0;
    e = 32'd0;
`endif
    do_reset();
    // do_reset leaves us just after the falling edge following the reset
    // edge (count 0); ten more rising edges give 10.
    repeat (10) @(negedge CLK);
    ALU_result = A_CYCLE;
    MemWriteM = 1'b0;
    #1;
    n_cmp++; if (Read_Data !== e) begin n_fail++; $display("FAIL cycle_at_10 got %h want %h", Read_Data, e); end
    drive(A_CYCLE, 32'hFFFF_FFFE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(A_CYCLE, 32'h0, 1'b0);
      n_cmp++; if (Read_Data !== exp_seq[i]) begin n_fail++; $display("FAIL cycle_seq_%0d got %h want %h", i, Read_Data, exp_seq[i]); end
    end
  endtask

  task automatic test_unmapped_rdw();
    drive(32'h8000_0010, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got %h want 0", Read_Data); end
    drive(32'h8000_0010, 32'hFFFF_FFFF, 1'b1);
    drive(A_GPIO, 32'h0, 1'b0);
    n_cmp++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL unmapped_wr_gpio got %h want 0", gpio_out); end
    drive(32'h0000_0000, 32'h5A5A_0F0F, 1'b1);
    drive(32'h0000_0000, 32'h0000_0001, 1'b1);
    n_cmp++; if (Read_Data !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL rdw_old got %h want %h", Read_Data, 32'h5A5A_0F0F); end
    drive(32'h0000_0000, 32'h0, 1'b0);
    n_cmp++; if (Read_Data !== 32'h1) begin n_fail++; $display("FAIL rdw_new got %h want %h", Read_Data, 32'h1); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    RST = 1'b1;
    ALU_result = '0;
    Write_Data = '0;
    MemWriteM = 1'b0;
    tx_ready = 1'b0;
    test_reset();
    test_ram();
    test_gpio_reset();
    test_reset_mid();
    test_fifo_fill();
    test_back_to_back();
    test_cycle();
    test_unmapped_rdw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
